// File: rtl/mux_arbiter_pkg.sv
// rtl/mux_arbiter_pkg.sv - shared constants and types for the mux arbiter
package mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] SEL_A = 4'd0;
  localparam logic [SEL_W-1:0] SEL_B = 4'd1;
  localparam logic [SEL_W-1:0] SEL_C = 4'd2;
  localparam logic [SEL_W-1:0] SEL_D = 4'd3;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick
  import mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic               found_o,
  output logic [1:0]         winner_o
);

  // Scan from the highest offset down so the nearest requester after ptr wins last
  always_comb begin
    logic [1:0] idx;
    found_o  = 1'b0;
    winner_o = ptr_i;
    idx      = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_i + k[1:0];
      if (req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin burst arbiter driving the shared 4:1 data mux
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [DW-1:0]      a,
  input  logic [DW-1:0]      b,
  input  logic [DW-1:0]      c,
  input  logic [DW-1:0]      d,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy
);

  // Beat index at which the budget forces the grant to end
  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;

  logic             found;
  logic [1:0]       winner;

  rr_pick u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

  // Output decode: stream signals are combinational from inputs and owner state
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    gnt       = '0;
    if (state_q == ST_GRANT) begin
      out_valid = req[owner_q];
      case (owner_q)
        2'd0: out_data = a;
        2'd1: out_data = b;
        2'd2: out_data = c;
        2'd3: out_data = d;
      endcase
      out_last     = out_valid && (last[owner_q] || (beat_cnt_q == LAST_CNT));
      gnt[owner_q] = 1'b1;
    end
  end

  assign busy = (state_q == ST_GRANT);
  assign sel  = sel_q;

  // Next-state: grant a winner from IDLE, count beats and release at end of burst
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    sel_d      = sel_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_GRANT;
          owner_d    = winner;
          sel_d      = {{(SEL_W-2){1'b0}}, winner};
          ptr_d      = winner + 2'd1;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (out_valid && out_ready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (out_last) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // State registers; sel holds through IDLE so the mux select never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'd0;
      owner_q    <= 2'd0;
      sel_q      <= SEL_A;
      beat_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - self-checking bench for mux_arbiter against a burst-level model
module tb_mux_arbiter;

  localparam int DW        = 4;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req, last;
  logic [DW-1:0] a, b, c, d;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [3:0]    gnt;
  logic [3:0]    sel;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: who owns the bus, how many beats it has sent, where the scan resumes
  bit m_busy;
  int m_owner, m_ptr, m_beats, m_sel;

  mux_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] src(input int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  task automatic m_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_beats = 0;
    m_sel   = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic m_update();
    if (!rst_n) begin
      m_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (req[idx]) begin
          m_busy  = 1'b1;
          m_owner = idx;
          m_sel   = idx;
          m_ptr   = (idx + 1) % 4;
          m_beats = 0;
          break;
        end
      end
    end else if (req[m_owner] && out_ready) begin
      if (last[m_owner] || (m_beats + 1 == MAX_BURST)) m_busy = 1'b0;
      else m_beats++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic       e_valid;
    logic [3:0] e_gnt;
    e_valid = m_busy && req[m_owner];
    e_gnt   = m_busy ? 4'(1 << m_owner) : 4'd0;
    check_eq({tag, "_busy"},  32'(busy),      32'(m_busy));
    check_eq({tag, "_gnt"},   32'(gnt),       32'(e_gnt));
    check_eq({tag, "_sel"},   32'(sel),       32'(m_sel));
    check_eq({tag, "_valid"}, 32'(out_valid), 32'(e_valid));
    check_eq({tag, "_data"},  32'(out_data),  m_busy ? 32'(src(m_owner)) : 32'd0);
    check_eq({tag, "_last"},  32'(out_last),
             32'(e_valid && (last[m_owner] || (m_beats == MAX_BURST - 1))));
  endtask

  // Apply inputs after a falling edge, then check outputs against the model
  task automatic apply(input logic [3:0] r, input logic [3:0] l, input logic rdy, input string tag);
    req       = r;
    last      = l;
    out_ready = rdy;
    #1;
    compare_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply(4'b0000, 4'b0000, 1'b0, "rst");
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;

    // Single request from source c, two beats
    c = 4'h9;
    apply(4'b0100, 4'b0000, 1'b1, "t1_req"); tick();
    check_eq("t1_gnt", 32'(gnt), 32'h4);
    check_eq("t1_sel", 32'(sel), 32'd2);
    apply(4'b0100, 4'b0000, 1'b1, "t1_b1");
    check_eq("t1_b1_data", 32'(out_data), 32'h9);
    tick();
    apply(4'b0100, 4'b0100, 1'b1, "t1_b2");
    check_eq("t1_b2_last", 32'(out_last), 32'd1);
    tick();
    apply(4'b0000, 4'b0000, 1'b1, "t1_end");
    check_eq("t1_end_gnt", 32'(gnt), 32'd0);
    tick();

    // Round-robin fairness from a fresh reset
    rst_n = 1'b0; m_reset(); #1; rst_n = 1'b1; @(negedge clk);
    a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
    for (int i = 0; i < 10; i++) begin
      apply(4'b1111, 4'b1111, 1'b1, "rr"); tick();
      check_eq("rr_order", 32'(gnt), (i % 2 == 0) ? 32'(1 << ((i / 2) % 4)) : 32'd0);
    end

    // Backpressure on owner 1 (scan resumes at 1)
    b = 4'h5;
    apply(4'b0010, 4'b0000, 1'b0, "bp_req"); tick();
    for (int i = 0; i < 3; i++) begin
      apply(4'b0010, 4'b0010, 1'b0, "bp_hold");
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_data", 32'(out_data), 32'h5);
      tick();
    end
    apply(4'b0010, 4'b0010, 1'b1, "bp_go"); tick();
    apply(4'b0000, 4'b0000, 1'b1, "bp_idle");
    check_eq("bp_idle_gnt", 32'(gnt), 32'd0);
    tick();

    // Forced release after MAX_BURST beats from source 3, then source 0 waits
    apply(4'b1001, 4'b0000, 1'b1, "fr_req"); tick();
    check_eq("fr_gnt", 32'(gnt), 32'h8);
    for (int i = 0; i < MAX_BURST; i++) begin
      d = 4'($urandom);
      apply(4'b1001, 4'b0000, 1'b1, "fr_beat");
      check_eq("fr_last", 32'(out_last), (i == MAX_BURST - 1) ? 32'd1 : 32'd0);
      tick();
    end
    apply(4'b1001, 4'b0000, 1'b1, "fr_idle"); tick();
    check_eq("fr_next_gnt", 32'(gnt), 32'h1);

    // Owner 0 stalls while source 1 keeps requesting
    apply(4'b0011, 4'b0000, 1'b1, "st_b1"); tick();
    for (int i = 0; i < 2; i++) begin
      apply(4'b0010, 4'b0000, 1'b1, "st_gap");
      check_eq("st_valid", 32'(out_valid), 32'd0);
      check_eq("st_gnt", 32'(gnt), 32'h1);
      tick();
    end
    apply(4'b0011, 4'b0001, 1'b1, "st_end"); tick();
    apply(4'b0010, 4'b0000, 1'b1, "st_idle"); tick();
    check_eq("st_next_gnt", 32'(gnt), 32'h2);

    // Reset in the middle of source 1's burst
    apply(4'b0010, 4'b0000, 1'b1, "mr_b1"); tick();
    apply(4'b0010, 4'b0000, 1'b1, "mr_b2");
    rst_n = 1'b0; m_reset(); #1;
    compare_all("mr_rst");
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    apply(4'b1111, 4'b0000, 1'b1, "mr_req"); tick();
    check_eq("mr_restart_gnt", 32'(gnt), 32'h1);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        m_reset();
      end else begin
        rst_n = 1'b1;
      end
      apply(4'($urandom_range(0, 15)),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
            ($urandom_range(0, 3) != 0), "rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
